// File: rtl/c5_pc_seq_pkg.sv
// Shared definitions for the c5 program-counter sequencer: PC source codes,
// sequencer state encoding and default vectors.
package c5_pkg;
  localparam logic [1:0] PC_SRC_INC    = 2'd0;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd1;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd2;
  localparam logic [1:0] PC_SRC_REG    = 2'd3;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_EXC  = 2'd2
  } state_t;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_003C;
endpackage

// File: rtl/c5_pc_seq_inc.sv
// Word-address incrementer shared by fetch (next PC) and link (PC+4); carry-out dropped.
module c5_inc #(
  parameter int WIDTH = 30
) (
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  assign q = d + {{(WIDTH-1){1'b0}}, 1'b1};
endmodule

// File: rtl/c5_pc_seq.sv
// Program-counter sequencer: picks the next fetch address (inc/jump/branch/reg/exception/eret).
// Optional MIPS branch delay slot behaviour enabled by defining C5_PC_DELAY_SLOT_EN.
module c5_pc_seq
  import c5_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC)
) (
  input  logic             I_clk,
  input  logic             I_reset_n,
  input  logic             I_pause,
  input  logic [1:0]       I_pc_source,
  input  logic             I_take_branch,
  input  logic [25:0]      I_opcode25_0,
  input  logic [WIDTH-1:0] I_pc_new,
  input  logic             I_intr,
  input  logic             I_eret,
  output logic [WIDTH-1:0] O_pc,
  output logic [WIDTH-1:0] O_pc_plus4,
  output logic             O_fetch_valid,
  output logic [WIDTH-1:0] O_epc,
  output logic             O_intr_mask
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, epc_q, epc_d;
  logic             mask_q, mask_d;
  logic [WIDTH-3:0] word_inc;
  logic [WIDTH-1:0] pc_new_al, redir_tgt;
  logic             redir_vld, intr_take;
`ifdef C5_PC_DELAY_SLOT_EN
  logic             pend_vld_q, pend_vld_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
`endif

  c5_inc #(.WIDTH(WIDTH-2)) u_inc (.d(pc_q[WIDTH-1:2]), .q(word_inc));

  assign O_pc_plus4    = {word_inc, 2'b00};
  assign O_pc          = pc_q;
  assign O_epc         = epc_q;
  assign O_intr_mask   = mask_q;
  assign O_fetch_valid = (state_q == ST_RUN);
  assign pc_new_al     = I_pc_new & ~WIDTH'(3);
  assign intr_take     = I_intr & ~mask_q;

  // eret outranks the decoded source; it shares the redirect path
  always_comb begin
    redir_vld = 1'b0;
    redir_tgt = O_pc_plus4;
    if (I_eret) begin
      redir_vld = 1'b1;
      redir_tgt = epc_q;
    end else begin
      case (I_pc_source)
        PC_SRC_JUMP: begin
          redir_vld = 1'b1;
          redir_tgt = {pc_q[WIDTH-1:28], I_opcode25_0, 2'b00};
        end
        PC_SRC_BRANCH: if (I_take_branch) begin
          redir_vld = 1'b1;
          redir_tgt = pc_new_al;
        end
        PC_SRC_REG: begin
          redir_vld = 1'b1;
          redir_tgt = pc_new_al;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    mask_d  = mask_q;
`ifdef C5_PC_DELAY_SLOT_EN
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
`endif
    if (!I_pause) begin
      case (state_q)
        ST_BOOT, ST_EXC: state_d = ST_RUN;
        ST_RUN: begin
`ifdef C5_PC_DELAY_SLOT_EN
          // slot instruction is issuing now; target goes next, everything else waits
          if (pend_vld_q) begin
            pc_d       = pend_tgt_q;
            pend_vld_d = 1'b0;
          end else if (intr_take) begin
            epc_d   = O_pc_plus4;
            pc_d    = EXC_VEC;
            mask_d  = 1'b1;
            state_d = ST_EXC;
          end else begin
            pc_d = O_pc_plus4;
            if (redir_vld) begin
              pend_vld_d = 1'b1;
              pend_tgt_d = redir_tgt;
            end
            if (I_eret) mask_d = 1'b0;
          end
`else
          if (intr_take) begin
            epc_d   = redir_vld ? redir_tgt : O_pc_plus4;
            pc_d    = EXC_VEC;
            mask_d  = 1'b1;
            state_d = ST_EXC;
          end else begin
            pc_d = redir_vld ? redir_tgt : O_pc_plus4;
            if (I_eret) mask_d = 1'b0;
          end
`endif
        end
        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      mask_q  <= 1'b1;
`ifdef C5_PC_DELAY_SLOT_EN
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      mask_q  <= mask_d;
`ifdef C5_PC_DELAY_SLOT_EN
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
`endif
    end
  end
endmodule

// File: tb/tb_c5_pc_seq.sv
// Directed vector bench for c5_pc_seq; delay-slot sequence runs when C5_PC_DELAY_SLOT_EN is defined.
module tb_c5_pc_seq;
  logic        clk = 1'b0;
  logic        rst_n, pause, take, intr, eret;
  logic [1:0]  src;
  logic [25:0] op;
  logic [31:0] pnew;
  logic [31:0] pc, pc4, epc;
  logic        vld, mask;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  c5_pc_seq dut (
    .I_clk(clk), .I_reset_n(rst_n), .I_pause(pause), .I_pc_source(src),
    .I_take_branch(take), .I_opcode25_0(op), .I_pc_new(pnew), .I_intr(intr),
    .I_eret(eret), .O_pc(pc), .O_pc_plus4(pc4), .O_fetch_valid(vld),
    .O_epc(epc), .O_intr_mask(mask)
  );

  typedef struct {
    bit rst_n, pause; logic [1:0] src; bit take; logic [25:0] op; logic [31:0] pnew;
    bit intr, eret; logic [31:0] e_pc; bit e_vld; logic [31:0] e_epc; bit e_mask;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit p, logic [1:0] s, bit t, logic [25:0] o,
                              logic [31:0] n, bit i, bit e, logic [31:0] xpc, bit xv,
                              logic [31:0] xepc, bit xm);
    vec_t v;
    v.rst_n = r; v.pause = p; v.src = s; v.take = t; v.op = o; v.pnew = n;
    v.intr = i; v.eret = e; v.e_pc = xpc; v.e_vld = xv; v.e_epc = xepc; v.e_mask = xm;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drv(bit r, bit p, logic [1:0] s, bit t, logic [31:0] n, bit i, bit e);
    rst_n = r; pause = p; src = s; take = t; pnew = n; intr = i; eret = e;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(string tag, logic [31:0] xpc, bit xv, logic [31:0] xepc, bit xm);
    chk({tag, " pc"}, pc, xpc);
    chk({tag, " pc4"}, pc4, xpc + 32'd4);
    chk({tag, " vld"}, {31'd0, vld}, {31'd0, xv});
    chk({tag, " epc"}, epc, xepc);
    chk({tag, " mask"}, {31'd0, mask}, {31'd0, xm});
  endtask

  initial begin
    drv(0, 0, 2'd0, 0, 32'h0, 0, 0);
    op = '0;
`ifndef C5_PC_DELAY_SLOT_EN
    //            rst p  src take op      pnew          intr eret  pc            vld epc        mask
    vecs.push_back(mk(0, 0, 2'd0, 0, 26'h0,   32'h0,         0, 0, 32'h0,         0, 32'h0,   1));
    vecs.push_back(mk(1, 0, 2'd0, 0, 26'h0,   32'h0,         0, 0, 32'h0,         1, 32'h0,   1));
    vecs.push_back(mk(1, 0, 2'd0, 0, 26'h0,   32'h0,         0, 0, 32'h4,         1, 32'h0,   1));
    vecs.push_back(mk(1, 0, 2'd0, 0, 26'h0,   32'h0,         0, 0, 32'h8,         1, 32'h0,   1));
    vecs.push_back(mk(1, 0, 2'd0, 0, 26'h0,   32'h0,         0, 0, 32'hC,         1, 32'h0,   1));
    vecs.push_back(mk(1, 0, 2'd0, 0, 26'h0,   32'h0,         0, 0, 32'h10,        1, 32'h0,   1));
    vecs.push_back(mk(1, 1, 2'd0, 0, 26'h0,   32'h0,         0, 0, 32'h10,        1, 32'h0,   1));
    vecs.push_back(mk(1, 1, 2'd3, 0, 26'h0,   32'h999,       1, 1, 32'h10,        1, 32'h0,   1));
    vecs.push_back(mk(1, 1, 2'd0, 0, 26'h0,   32'h0,         0, 0, 32'h10,        1, 32'h0,   1));
    vecs.push_back(mk(1, 0, 2'd0, 0, 26'h0,   32'h0,         0, 0, 32'h14,        1, 32'h0,   1));
    vecs.push_back(mk(1, 0, 2'd3, 0, 26'h0,   32'h2000_0010, 0, 0, 32'h2000_0010, 1, 32'h0,   1));
    vecs.push_back(mk(1, 0, 2'd1, 0, 26'h100, 32'h0,         0, 0, 32'h2000_0400, 1, 32'h0,   1));
    vecs.push_back(mk(1, 0, 2'd3, 0, 26'h0,   32'h87,        0, 0, 32'h84,        1, 32'h0,   1));
    vecs.push_back(mk(1, 0, 2'd2, 0, 26'h0,   32'h500,       0, 0, 32'h88,        1, 32'h0,   1));
    vecs.push_back(mk(1, 0, 2'd2, 1, 26'h0,   32'h500,       0, 0, 32'h500,       1, 32'h0,   1));
    vecs.push_back(mk(1, 0, 2'd0, 0, 26'h0,   32'h0,         1, 0, 32'h504,       1, 32'h0,   1));
    vecs.push_back(mk(1, 0, 2'd0, 0, 26'h0,   32'h0,         0, 1, 32'h0,         1, 32'h0,   0));
    vecs.push_back(mk(1, 0, 2'd3, 0, 26'h0,   32'h40,        0, 0, 32'h40,        1, 32'h0,   0));
    vecs.push_back(mk(1, 0, 2'd0, 0, 26'h0,   32'h0,         1, 0, 32'h3C,        0, 32'h44,  1));
    vecs.push_back(mk(1, 0, 2'd0, 0, 26'h0,   32'h0,         1, 0, 32'h3C,        1, 32'h44,  1));
    vecs.push_back(mk(1, 0, 2'd0, 0, 26'h0,   32'h0,         0, 1, 32'h44,        1, 32'h44,  0));
    vecs.push_back(mk(1, 0, 2'd0, 0, 26'h0,   32'h0,         1, 1, 32'h3C,        0, 32'h44,  1));
    vecs.push_back(mk(1, 0, 2'd0, 0, 26'h0,   32'h0,         0, 0, 32'h3C,        1, 32'h44,  1));
    vecs.push_back(mk(1, 0, 2'd0, 0, 26'h0,   32'h0,         1, 1, 32'h44,        1, 32'h44,  0));
    vecs.push_back(mk(1, 0, 2'd3, 0, 26'h0,   32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1, 32'h44,  0));
    vecs.push_back(mk(1, 0, 2'd0, 0, 26'h0,   32'h0,         0, 0, 32'h0,         1, 32'h44,  0));
    vecs.push_back(mk(1, 0, 2'd3, 0, 26'h0,   32'h80,        0, 0, 32'h80,        1, 32'h44,  0));
    vecs.push_back(mk(1, 0, 2'd1, 0, 26'h40,  32'h0,         1, 0, 32'h3C,        0, 32'h100, 1));
    vecs.push_back(mk(1, 1, 2'd0, 0, 26'h0,   32'h0,         0, 0, 32'h3C,        0, 32'h100, 1));
    vecs.push_back(mk(0, 0, 2'd0, 0, 26'h0,   32'h0,         0, 0, 32'h0,         0, 32'h0,   1));
    vecs.push_back(mk(1, 1, 2'd0, 0, 26'h0,   32'h0,         0, 0, 32'h0,         0, 32'h0,   1));
    vecs.push_back(mk(1, 0, 2'd0, 0, 26'h0,   32'h0,         0, 0, 32'h0,         1, 32'h0,   1));
    vecs.push_back(mk(1, 0, 2'd0, 0, 26'h0,   32'h0,         0, 0, 32'h4,         1, 32'h0,   1));

    #2;
    foreach (vecs[i]) begin
      drv(vecs[i].rst_n, vecs[i].pause, vecs[i].src, vecs[i].take, vecs[i].pnew,
          vecs[i].intr, vecs[i].eret);
      op = vecs[i].op;
      tick();
      chk_all($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_vld, vecs[i].e_epc, vecs[i].e_mask);
    end

    // alternating stall/advance from pc=4: advance on even steps only
    begin
      logic [31:0] exp_pc;
      exp_pc = 32'h4;
      for (int k = 0; k < 8; k++) begin
        drv(1, k[0], 2'd0, 0, 32'h0, 0, 0);
        tick();
        if (!k[0]) exp_pc = exp_pc + 32'd4;
        chk_all($sformatf("stall%0d", k), exp_pc, 1'b1, 32'h0, 1'b1);
      end
    end
`else
    #2;
    drv(0, 0, 2'd0, 0, 32'h0, 0, 0); tick(); chk_all("ds_rst", 32'h0, 0, 32'h0, 1);
    drv(1, 0, 2'd0, 0, 32'h0, 0, 0); tick(); chk_all("ds_boot", 32'h0, 1, 32'h0, 1);
    drv(1, 0, 2'd0, 0, 32'h0, 0, 1); tick(); chk_all("ds_eret_slot", 32'h4, 1, 32'h0, 0);
    drv(1, 0, 2'd0, 0, 32'h0, 0, 0); tick(); chk_all("ds_eret_tgt", 32'h0, 1, 32'h0, 0);
    drv(1, 0, 2'd3, 0, 32'h100, 0, 0); tick(); chk_all("ds_reg_slot", 32'h4, 1, 32'h0, 0);
    drv(1, 0, 2'd0, 0, 32'h0, 0, 0); tick(); chk_all("ds_reg_tgt", 32'h100, 1, 32'h0, 0);
    drv(1, 0, 2'd2, 1, 32'h200, 0, 0); tick(); chk_all("ds_br_slot", 32'h104, 1, 32'h0, 0);
    drv(1, 0, 2'd2, 1, 32'h300, 1, 0); tick(); chk_all("ds_br_tgt", 32'h200, 1, 32'h0, 0);
    drv(1, 0, 2'd0, 0, 32'h0, 1, 0); tick(); chk_all("ds_exc", 32'h3C, 0, 32'h204, 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
